// File: rtl/pkg_cpu.sv
// CPU bus encodings shared by the spcpu core and its bus-side peripherals.
package pkg_cpu;

    // Access-size encoding on data_acc_sz
    localparam logic cpu_data_acc_sz_8  = 1'b0;
    localparam logic cpu_data_acc_sz_16 = 1'b1;

endpackage

// File: rtl/pkg_mem_ctrl.sv
// Types and constants for the spcpu block-RAM memory controller.
package pkg_mem_ctrl;

    // Width of the programmable wait-state down-counter (0..15 wait states)
    localparam int mem_ctrl_wait_cnt_width = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACC_LO,
        ACC_HI,
        DONE
    } mem_ctrl_state_t;

    // A 16-bit access at an odd byte address straddles two RAM words
    function automatic logic is_unaligned16(input logic addr_lsb, input logic acc_sz);
        return addr_lsb && (acc_sz == pkg_cpu::cpu_data_acc_sz_16);
    endfunction

endpackage

// File: rtl/spcpu_mem_ctrl_lane_steer.sv
// Byte-lane steering between the CPU view (little-endian bytes) and the
// word-wide RAM: byte enables, write-data placement and read assembly.
module spcpu_mem_ctrl_lane_steer
    import pkg_cpu::*;
(
    input  logic        byte_sel,
    input  logic        acc_sz,
    input  logic        phase_hi,
    input  logic [15:0] cpu_wdata,
    input  logic [15:0] ram_rdata,
    input  logic [7:0]  lo_byte,
    output logic [1:0]  lane_be,
    output logic [15:0] lane_wdata,
    output logic [15:0] cpu_rdata
);

    // Choose lanes by size and byte offset; aligned 16-bit passes straight through
    always_comb begin
        lane_be    = 2'b11;
        lane_wdata = cpu_wdata;
        cpu_rdata  = ram_rdata;
        if (acc_sz == cpu_data_acc_sz_8) begin
            lane_be    = byte_sel ? 2'b10 : 2'b01;
            lane_wdata = {cpu_wdata[7:0], cpu_wdata[7:0]};
            cpu_rdata  = {8'h00, (byte_sel ? ram_rdata[15:8] : ram_rdata[7:0])};
        end else if (byte_sel) begin
            // Unaligned: low byte rides lane 1 of the first word, high byte
            // rides lane 0 of the next word, so the data is byte-swapped.
            lane_be    = phase_hi ? 2'b01 : 2'b10;
            lane_wdata = {cpu_wdata[7:0], cpu_wdata[15:8]};
            cpu_rdata  = {ram_rdata[7:0], lo_byte};
        end
    end

endmodule

// File: rtl/spcpu_mem_ctrl.sv
// spcpu memory controller: turns one-cycle CPU bus requests into one or two
// RAM cycles after a programmable number of wait states, and returns a
// one-cycle data_ready pulse with the assembled read data.
module spcpu_mem_ctrl
    import pkg_cpu::*;
    import pkg_mem_ctrl::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_rdwr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  data_acc_sz,
    input  logic                  data_inout_we,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    output logic [DATA_WIDTH-1:0] read_data_out,
    output logic                  data_ready,
    output logic                  busy,
    output logic                  req_dropped,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [1:0]            ram_be,
    output logic [ADDR_WIDTH-2:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [mem_ctrl_wait_cnt_width-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? mem_ctrl_wait_cnt_width'(WAIT_STATES - 1) : '0;

    mem_ctrl_state_t                    state;
    mem_ctrl_state_t                    state_next;
    logic [mem_ctrl_wait_cnt_width-1:0] wait_cnt;
    logic [mem_ctrl_wait_cnt_width-1:0] wait_cnt_next;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_sz;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [7:0]            lo_byte;

    logic                  access;
    logic                  phase_hi;
    logic                  unaligned;
    logic [ADDR_WIDTH-2:0] word_addr;
    logic [1:0]            steer_be;
    logic [DATA_WIDTH-1:0] steer_wdata;
    logic [DATA_WIDTH-1:0] steer_rdata;

    assign unaligned = is_unaligned16(lat_addr[0], lat_sz);
    assign word_addr = lat_addr[ADDR_WIDTH-1:1];

    // State register and wait counter; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state logic plus the per-state RAM strobe and completion pulse
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        access        = 1'b0;
        phase_hi      = 1'b0;
        data_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (req_rdwr) begin
                    if (WAIT_STATES > 0) begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = ACC_LO;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = ACC_LO;
                end else begin
                    wait_cnt_next = wait_cnt - 1'b1;
                end
            end
            ACC_LO: begin
                access     = 1'b1;
                state_next = unaligned ? ACC_HI : DONE;
            end
            ACC_HI: begin
                access     = 1'b1;
                phase_hi   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                data_ready = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request only when it is accepted from IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_addr  <= '0;
            lat_sz    <= cpu_data_acc_sz_8;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
        end else if (state == IDLE && req_rdwr) begin
            lat_addr  <= addr_in;
            lat_sz    <= data_acc_sz;
            lat_we    <= data_inout_we;
            lat_wdata <= write_data_in;
        end
    end

    // First word of an unaligned read arrives during ACC_HI; keep its lane 1
    always_ff @(posedge clk) begin
        if (!reset) begin
            lo_byte <= '0;
        end else if (state == ACC_HI) begin
            lo_byte <= ram_rdata[15:8];
        end
    end

    // Sticky flag for requests that arrive while an access is still running
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_dropped <= 1'b0;
        end else if (req_rdwr && state != IDLE) begin
            req_dropped <= 1'b1;
        end
    end

    spcpu_mem_ctrl_lane_steer u_lane_steer (
        .byte_sel   (lat_addr[0]),
        .acc_sz     (lat_sz),
        .phase_hi   (phase_hi),
        .cpu_wdata  (lat_wdata),
        .ram_rdata  (ram_rdata),
        .lo_byte    (lo_byte),
        .lane_be    (steer_be),
        .lane_wdata (steer_wdata),
        .cpu_rdata  (steer_rdata)
    );

    assign busy          = (state != IDLE);
    assign ram_en        = access;
    assign ram_we        = access & lat_we;
    assign ram_be        = access ? steer_be : 2'b00;
    assign ram_addr      = access ? (phase_hi ? word_addr + 1'b1 : word_addr) : '0;
    assign ram_wdata     = access ? steer_wdata : '0;
    assign read_data_out = (data_ready && !lat_we) ? steer_rdata : '0;

endmodule

// File: tb/tb_spcpu_mem_ctrl.sv
// Self-checking bench for spcpu_mem_ctrl with a one-cycle-latency RAM model.
module tb_spcpu_mem_ctrl;
    import pkg_cpu::*;

    localparam int W = 2;

    typedef struct {
        logic        we;
        logic        sz;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          nops;
        logic [14:0] a0;
        logic [1:0]  be0;
        logic [15:0] wd0;
        logic [14:0] a1;
        logic [1:0]  be1;
        logic [15:0] wd1;
    } vec_t;

    typedef struct {
        logic [14:0] addr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wdata;
        int          cyc;
    } op_t;

    typedef struct {
        logic [15:0] rdata;
        int          cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_rdwr;
    logic [15:0] addr_in;
    logic        data_acc_sz;
    logic        data_inout_we;
    logic [15:0] write_data_in;
    logic [15:0] read_data_out;
    logic        data_ready;
    logic        busy;
    logic        req_dropped;
    logic        ram_en;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] mem [0:32767];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    op_t         opQ[$];
    res_t        resQ[$];
    op_t         mon_op;
    res_t        mon_res;
    logic [15:0] mon_mask;
    vec_t        vecs[18];

    spcpu_mem_ctrl #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .WAIT_STATES (W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_rdwr      (req_rdwr),
        .addr_in       (addr_in),
        .data_acc_sz   (data_acc_sz),
        .data_inout_we (data_inout_we),
        .write_data_in (write_data_in),
        .read_data_out (read_data_out),
        .data_ready    (data_ready),
        .busy          (busy),
        .req_dropped   (req_dropped),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_be        (ram_be),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word RAM with byte enables and one cycle of read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we && ram_be[0]) mem[ram_addr][7:0] <= ram_wdata[7:0];
            if (ram_we && ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard side: every RAM strobe and completion pulse is popped and compared
    always @(negedge clk) begin
        if (ram_en === 1'b1) begin
            if (opQ.size() == 0) begin
                checkOutput("unexpected_ram_en", 32'(ram_en), 32'd0);
            end else begin
                mon_op   = opQ.pop_front();
                mon_mask = {{8{mon_op.be[1]}}, {8{mon_op.be[0]}}};
                checkOutput("ram_en_cycle", 32'(cyc), 32'(mon_op.cyc));
                checkOutput("ram_addr", 32'(ram_addr), 32'(mon_op.addr));
                checkOutput("ram_be", 32'(ram_be), 32'(mon_op.be));
                checkOutput("ram_we", 32'(ram_we), 32'(mon_op.we));
                if (mon_op.we)
                    checkOutput("ram_wdata", 32'(ram_wdata & mon_mask), 32'(mon_op.wdata & mon_mask));
            end
        end
        if (data_ready === 1'b1) begin
            if (resQ.size() == 0) begin
                checkOutput("unexpected_data_ready", 32'(data_ready), 32'd0);
            end else begin
                mon_res = resQ.pop_front();
                checkOutput("data_ready_cycle", 32'(cyc), 32'(mon_res.cyc));
                checkOutput("read_data_out", 32'(read_data_out), 32'(mon_res.rdata));
                checkOutput("busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    // Drive one request pulse and push what the RAM side and CPU side should see
    task automatic applyStimulus(input vec_t v);
        op_t  op;
        res_t res;
        int   t;
        t             = cyc;
        req_rdwr      = 1'b1;
        addr_in       = v.addr;
        data_acc_sz   = v.sz;
        data_inout_we = v.we;
        write_data_in = v.wdata;
        op = '{v.a0, v.be0, v.we, v.wd0, t + W + 1};
        opQ.push_back(op);
        if (v.nops == 2) begin
            op = '{v.a1, v.be1, v.we, v.wd1, t + W + 2};
            opQ.push_back(op);
        end
        res = '{v.rdata, t + W + 1 + v.nops};
        resQ.push_back(res);
        @(posedge clk); #1;
        req_rdwr = 1'b0;
    endtask

    // Bounded wait until the scoreboard has seen the completion pulse
    task automatic waitDone();
        for (int i = 0; i < 40 && resQ.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (resQ.size() != 0) begin
            checkOutput("completion_timeout", 32'(resQ.size()), 32'd0);
            resQ.delete();
            opQ.delete();
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        checkOutput({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        checkOutput({tag, "_ram_be"}, 32'(ram_be), 32'd0);
        checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        checkOutput({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        checkOutput({tag, "_data_ready"}, 32'(data_ready), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_read_data_out"}, 32'(read_data_out), 32'd0);
        checkOutput({tag, "_req_dropped"}, 32'(req_dropped), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        //          we    sz                  addr      wdata     rdata     n  a0        be0    wd0       a1        be1    wd1
        vecs[0]  = '{1'b1, cpu_data_acc_sz_16, 16'h0010, 16'h1234, 16'h0000, 1, 15'h0008, 2'b11, 16'h1234, 15'h0000, 2'b00, 16'h0000};
        vecs[1]  = '{1'b0, cpu_data_acc_sz_16, 16'h0010, 16'h0000, 16'h1234, 1, 15'h0008, 2'b11, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        vecs[2]  = '{1'b1, cpu_data_acc_sz_8,  16'h0011, 16'h55AB, 16'h0000, 1, 15'h0008, 2'b10, 16'hABAB, 15'h0000, 2'b00, 16'h0000};
        vecs[3]  = '{1'b0, cpu_data_acc_sz_8,  16'h0010, 16'h0000, 16'h0034, 1, 15'h0008, 2'b01, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        vecs[4]  = '{1'b0, cpu_data_acc_sz_8,  16'h0011, 16'h0000, 16'h00AB, 1, 15'h0008, 2'b10, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        vecs[5]  = '{1'b0, cpu_data_acc_sz_16, 16'h0010, 16'h0000, 16'hAB34, 1, 15'h0008, 2'b11, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        vecs[6]  = '{1'b1, cpu_data_acc_sz_16, 16'h0000, 16'h1111, 16'h0000, 1, 15'h0000, 2'b11, 16'h1111, 15'h0000, 2'b00, 16'h0000};
        vecs[7]  = '{1'b1, cpu_data_acc_sz_16, 16'hFFFF, 16'hBEEF, 16'h0000, 2, 15'h7FFF, 2'b10, 16'hEF00, 15'h0000, 2'b01, 16'h00BE};
        vecs[8]  = '{1'b0, cpu_data_acc_sz_16, 16'hFFFF, 16'h0000, 16'hBEEF, 2, 15'h7FFF, 2'b10, 16'h0000, 15'h0000, 2'b01, 16'h0000};
        vecs[9]  = '{1'b0, cpu_data_acc_sz_16, 16'h0000, 16'h0000, 16'h11BE, 1, 15'h0000, 2'b11, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        vecs[10] = '{1'b1, cpu_data_acc_sz_8,  16'h0100, 16'h005A, 16'h0000, 1, 15'h0080, 2'b01, 16'h5A5A, 15'h0000, 2'b00, 16'h0000};
        vecs[11] = '{1'b0, cpu_data_acc_sz_8,  16'h0100, 16'h0000, 16'h005A, 1, 15'h0080, 2'b01, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        vecs[12] = '{1'b1, cpu_data_acc_sz_16, 16'h0020, 16'hA5A5, 16'h0000, 1, 15'h0010, 2'b11, 16'hA5A5, 15'h0000, 2'b00, 16'h0000};
        vecs[13] = '{1'b1, cpu_data_acc_sz_16, 16'h0022, 16'h5A5A, 16'h0000, 1, 15'h0011, 2'b11, 16'h5A5A, 15'h0000, 2'b00, 16'h0000};
        vecs[14] = '{1'b1, cpu_data_acc_sz_16, 16'h0021, 16'hC3D2, 16'h0000, 2, 15'h0010, 2'b10, 16'hD200, 15'h0011, 2'b01, 16'h00C3};
        vecs[15] = '{1'b0, cpu_data_acc_sz_16, 16'h0020, 16'h0000, 16'hD2A5, 1, 15'h0010, 2'b11, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        vecs[16] = '{1'b0, cpu_data_acc_sz_16, 16'h0022, 16'h0000, 16'h5AC3, 1, 15'h0011, 2'b11, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        vecs[17] = '{1'b0, cpu_data_acc_sz_16, 16'h0021, 16'h0000, 16'hC3D2, 2, 15'h0010, 2'b10, 16'h0000, 15'h0011, 2'b01, 16'h0000};

        reset         = 1'b0;
        req_rdwr      = 1'b0;
        addr_in       = '0;
        data_acc_sz   = cpu_data_acc_sz_8;
        data_inout_we = 1'b0;
        write_data_in = '0;

        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Table of single transactions, issued back-to-back
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            waitDone();
        end

        // Second request while the first is waiting must be dropped
        checkOutput("req_dropped_before", 32'(req_dropped), 32'd0);
        v = '{1'b0, cpu_data_acc_sz_16, 16'h0010, 16'h0000, 16'hAB34, 1, 15'h0008, 2'b11, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        applyStimulus(v);
        req_rdwr      = 1'b1;
        addr_in       = 16'h0010;
        data_acc_sz   = cpu_data_acc_sz_16;
        data_inout_we = 1'b1;
        write_data_in = 16'hFFFF;
        @(posedge clk); #1;
        req_rdwr = 1'b0;
        checkOutput("req_dropped_set", 32'(req_dropped), 32'd1);
        checkOutput("busy_in_wait", 32'(busy), 32'd1);
        waitDone();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("req_dropped_sticky", 32'(req_dropped), 32'd1);
        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("ops_left_after_drop", 32'(opQ.size()), 32'd0);

        // Reset during WAIT aborts the write; nothing reaches the RAM
        req_rdwr      = 1'b1;
        addr_in       = 16'h0010;
        data_acc_sz   = cpu_data_acc_sz_16;
        data_inout_we = 1'b1;
        write_data_in = 16'h7777;
        @(posedge clk); #1;
        req_rdwr = 1'b0;
        reset    = 1'b0;
        @(posedge clk); #1;
        checkIdleOutputs("midreset");
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("mem_after_abort", 32'(mem[15'h0008]), 32'h0000AB34);

        // Requests after release complete normally
        applyStimulus(v);
        waitDone();
        v = '{1'b1, cpu_data_acc_sz_8, 16'h0010, 16'h00C7, 16'h0000, 1, 15'h0008, 2'b01, 16'hC7C7, 15'h0000, 2'b00, 16'h0000};
        applyStimulus(v);
        waitDone();
        v = '{1'b0, cpu_data_acc_sz_16, 16'h0010, 16'h0000, 16'hABC7, 1, 15'h0008, 2'b11, 16'h0000, 15'h0000, 2'b00, 16'h0000};
        applyStimulus(v);
        waitDone();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("final_ops_left", 32'(opQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spcpu_mem_ctrl.md
Name: spcpu_mem_ctrl

Overview:
Memory controller between the spcpu bus port (req_rdwr / data_ready handshake, 8/16-bit accesses) and a word-wide synchronous RAM with byte enables.
- Inserts programmable wait states.
- Steers byte lanes and returns read data to the CPU.
- Splits unaligned 16-bit accesses into two RAM cycles.
- Replaces the behavioural memory model wherever spcpu connects to real block RAM.

Parameters:
ADDR_WIDTH, 16, CPU byte-address width
DATA_WIDTH, 16, CPU/RAM data width (fixed 16; 8-bit accesses use one lane)
WAIT_STATES, 2, idle cycles inserted before each RAM access (0..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
req_rdwr  in  1  one-cycle request pulse; addr_in/data_acc_sz/data_inout_we/write_data_in valid that cycle
addr_in  in  ADDR_WIDTH  byte address
data_acc_sz  in  1  pkg_cpu::cpu_data_acc_sz_8 or cpu_data_acc_sz_16
data_inout_we  in  1  1 = write, 0 = read
write_data_in  in  16  write data (8-bit writes use [7:0])
read_data_out  out  16  read data, valid while data_ready=1
data_ready  out  1  one-cycle completion pulse
busy  out  1  1 from cycle after accepted req until data_ready cycle inclusive
req_dropped  out  1  sticky; set when req_rdwr arrives while busy
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable (qualified by ram_en)
ram_be  out  2  byte enables, bit0 = bits [7:0]
ram_addr  out  ADDR_WIDTH-1  word address
ram_wdata  out  16  RAM write data
ram_rdata  in  16  RAM read data, valid one cycle after ram_en (fixed latency 1)

Behaviour:
- Reset (reset=0 at clk edge):
  - All outputs 0; FSM to IDLE; wait counter 0; req_dropped cleared.
  - Reset mid-operation aborts the access: no further ram_en, no data_ready.
- Endianness little-endian: byte at even address = lane 0.
- FSM states:
  - IDLE: on req_rdwr=1, latch request; go to WAIT (WAIT_STATES>0, counter=WAIT_STATES-1), else ACC_LO.
  - WAIT: decrement counter; at 0 go to ACC_LO.
  - ACC_LO: ram_en=1 for this cycle.
    - Unaligned 16-bit (addr[0]=1 and sz=16): go to ACC_HI.
    - Otherwise go to DONE.
  - ACC_HI: ram_en=1 at word ((addr>>1)+1) mod 2^(ADDR_WIDTH-1) (wraps FFFF->0000), be=01; capture low byte from ram_rdata[15:8]; go to DONE.
  - DONE: data_ready=1, read_data_out valid; go to IDLE.
- Latency from req cycle T:
  - Aligned: ram_en at T+W+1, data_ready at T+W+2.
  - Unaligned 16-bit: ram_en at T+W+1 and T+W+2, data_ready at T+W+3.
- Lane rules:
  - 8-bit: be = addr[0] ? 10 : 01; ram_wdata = {b,b}; read_data_out = {8'h00, selected lane}.
  - 16-bit aligned: be=11; data passes straight through.
  - 16-bit unaligned: ACC_LO be=10 carries write_data_in[7:0] on lane 1; ACC_HI be=01 carries [15:8] on lane 0; read = {hi lane0, lo lane1}.
- ram_addr/ram_wdata/ram_be/ram_we are 0 when ram_en=0.
- read_data_out:
  - Writes return 0.
  - Reads hold value only in the DONE cycle, 0 otherwise.
- req_rdwr while busy=1 (including the DONE cycle): ignored; req_dropped <= 1.
- req_rdwr in the first IDLE cycle after DONE is accepted, giving back-to-back requests.

Decomposition:
- pkg_cpu: existing cpu_data_acc_sz_8/16 constants.
- New pkg_mem_ctrl:
  - typedef enum mem_ctrl_state_t {IDLE, WAIT, ACC_LO, ACC_HI, DONE};
  - constant mem_ctrl_wait_cnt_width = 4.
- Sub-module spcpu_mem_ctrl_lane_steer: combinational; computes be/wdata/read assembly from addr[0], size and phase.

Test Plan:
- W=2, aligned 16-bit write 0x1234 to 0x0010 at T=5 -> ram_en@8 with ram_addr=0x0008, be=11, wdata=0x1234, we=1; data_ready@9.
- Aligned 16-bit read at 0x0010 after that write -> data_ready@T+4, read_data_out=0x1234.
- 8-bit write 0xAB to 0x0011, then 8-bit read 0x0010 and 0x0011 -> write be=10, wdata=0xABAB; reads return 0x0034 and 0x00AB.
- Unaligned 16-bit write 0xBEEF to 0xFFFF -> ram_en on 2 consecutive cycles: addr 0x7FFF be=10 wdata[15:8]=0xEF, then addr 0x0000 be=01 wdata[7:0]=0xBE; readback returns 0xBEEF, data_ready@T+W+3.
- Second req_rdwr during WAIT -> ignored, no extra ram_en, req_dropped=1 until reset=0.
- reset=0 asserted during WAIT -> next cycle all outputs 0, no ram_en, no data_ready; new request after release completes normally.
